hssi_fifo_pkt_arb: RTL and testbench

HSSI_FIFO_PKT_ARB -- requirements
Module: hssi_fifo_pkt_arb

---
 rtl/hssi_fifo_arb_pkg.sv | 35 +++
 rtl/hssi_rr_sel.sv | 41 ++++
 rtl/hssi_fifo_pkt_arb.sv | 157 +++++++++++++++
 tb/tb_hssi_fifo_pkt_arb.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hssi_fifo_arb_pkg.sv
// -----------------------------------------------------------------------------
// hssi_fifo_arb_pkg
// Shared types and constants for the HSSI packet arbiter.
//   arb_state_e  : arbiter FSM state (IDLE / BUSY)
//   PKT_CNT_W    : width of the packet counter
//   *_pos/_lsb   : bit positions of the fields inside a fifo_data word, which
//                  is packed {src_id, sop, eop, payload} with payload at bit 0
// -----------------------------------------------------------------------------
package hssi_fifo_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  localparam int PKT_CNT_W   = 16;
  localparam int PAYLOAD_LSB = 0;

  function automatic int eop_pos(input int data_w);
    return data_w;
  endfunction

  function automatic int sop_pos(input int data_w);
    return data_w + 1;
  endfunction

  function automatic int src_lsb(input int data_w);
    return data_w + 2;
  endfunction

  function automatic int fifo_word_w(input int data_w, input int src_w);
    return data_w + src_w + 2;
  endfunction

endpackage

// File: rtl/hssi_rr_sel.sv
// -----------------------------------------------------------------------------
// hssi_rr_sel
// Combinational round-robin picker. Scans the request vector starting at
// last_i+1 (modulo NUM_REQ) and returns the first set index.
//   req_i   : request vector
//   last_i  : index of the previous winner
//   idx_o   : selected index (0 when nothing is requested)
//   found_o : at least one request was set
// -----------------------------------------------------------------------------
module hssi_rr_sel #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [IDX_W-1:0]   idx_o,
  output logic               found_o
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, so no path leaves it unassigned (no latch).
  always_comb begin
    idx_o    = '0;
    found_o  = 1'b0;
    cand     = 0;
    cand_idx = '0;
    // Offset 1 first, so the previous owner is checked last.
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand     = (int'(last_i) + k) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!found_o && req_i[cand_idx]) begin
        found_o = 1'b1;
        idx_o   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/hssi_fifo_pkt_arb.sv
// -----------------------------------------------------------------------------
// hssi_fifo_pkt_arb
// Packet-level round-robin arbiter feeding one shared scfifo. A requester owns
// the FIFO write port from its first beat through its eop beat; the grant
// never moves mid-packet. Accepted beats are registered onto fifo_data one
// cycle after acceptance.
//   clock, sclr        : clock, synchronous active-high reset
//   req_valid/sop/eop  : per-requester beat valid and packet markers
//   req_data           : per-requester payload, requester i at [i*DATA_W +: DATA_W]
//   req_ready          : per-requester beat accept (combinational)
//   fifo_wrreq/data    : write strobe and {src_id, sop, eop, payload} word
//   fifo_almost_full   : back-pressure from the FIFO (>= 2 words of slack)
//   grant              : one-hot current owner, zero when idle
//   proto_err          : sticky sop/eop sequencing error
//   pkt_cnt            : packets written, wraps at 16 bits
// NUM_REQ must lie in 2..8 and SRC_W must be >= clog2(NUM_REQ).
// -----------------------------------------------------------------------------
module hssi_fifo_pkt_arb
  import hssi_fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 64,
  parameter int SRC_W   = 3
) (
  input  logic                        clock,
  input  logic                        sclr,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_sop,
  input  logic [NUM_REQ-1:0]          req_eop,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        fifo_wrreq,
  output logic [DATA_W+SRC_W+2-1:0]   fifo_data,
  input  logic                        fifo_almost_full,
  output logic [NUM_REQ-1:0]          grant,
  output logic                        proto_err,
  output logic [PKT_CNT_W-1:0]        pkt_cnt
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int WORD_W = fifo_word_w(DATA_W, SRC_W);

  arb_state_e           state_q;
  logic [NUM_REQ-1:0]   grant_q;
  logic [IDX_W-1:0]     owner_q;
  logic [IDX_W-1:0]     last_owner_q;
  logic                 first_q;      // next accepted beat is the packet's first
  logic                 proto_err_q;
  logic                 wrreq_q;
  logic [WORD_W-1:0]    data_q;
  logic [PKT_CNT_W-1:0] pkt_cnt_q;
  logic [PKT_CNT_W-1:0] pkt_cnt_d;

  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_found;
  logic [NUM_REQ-1:0]   pick_onehot;

  logic [DATA_W-1:0]    data_arr [NUM_REQ];
  logic [DATA_W-1:0]    own_data;
  logic                 own_sop;
  logic                 own_eop;
  logic                 accept;
  logic                 sop_err;
  logic [WORD_W-1:0]    beat_word;

  hssi_rr_sel #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_sel (
    .req_i   (req_valid),
    .last_i  (last_owner_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
  end

  assign pick_onehot = NUM_REQ'(1) << pick_idx;

  // Only the owner can see ready, so at most one beat is accepted per cycle.
  assign req_ready = (state_q == ST_BUSY && !fifo_almost_full) ? grant_q : '0;
  assign accept    = |(req_valid & req_ready);

  assign own_data  = data_arr[owner_q];
  assign own_sop   = req_sop[owner_q];
  assign own_eop   = req_eop[owner_q];
  // sop must be present on the first beat and absent on every later one.
  assign sop_err   = first_q ^ own_sop;
  assign pkt_cnt_d = pkt_cnt_q + 1'b1;

  always_comb begin
    beat_word                            = '0;
    beat_word[PAYLOAD_LSB +: DATA_W]     = own_data;
    beat_word[eop_pos(DATA_W)]           = own_eop;
    beat_word[sop_pos(DATA_W)]           = own_sop;
    beat_word[src_lsb(DATA_W) +: SRC_W]  = SRC_W'(owner_q);
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (sclr) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      owner_q      <= '0;
      last_owner_q <= IDX_W'(NUM_REQ - 1);
      first_q      <= 1'b0;
      proto_err_q  <= 1'b0;
      wrreq_q      <= 1'b0;
      // NOTE: the output data register is cleared on reset too, so the FIFO
      // port never shows a stale word from before the reset.
      data_q       <= '0;
      pkt_cnt_q    <= '0;
    end else begin
      wrreq_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pick_found) begin
            grant_q <= pick_onehot;
            owner_q <= pick_idx;
            first_q <= 1'b1;
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (accept) begin
            wrreq_q <= 1'b1;
            data_q  <= beat_word;
            first_q <= 1'b0;
            if (sop_err) begin
              proto_err_q <= 1'b1;
            end
            if (own_eop) begin
              pkt_cnt_q    <= pkt_cnt_d;
              last_owner_q <= owner_q;
              grant_q      <= '0;
              state_q      <= ST_IDLE;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

  assign grant      = grant_q;
  assign fifo_wrreq = wrreq_q;
  assign fifo_data  = data_q;
  assign proto_err  = proto_err_q;
  assign pkt_cnt    = pkt_cnt_q;

endmodule

// File: tb/tb_hssi_fifo_pkt_arb.sv
// -----------------------------------------------------------------------------
// tb_hssi_fifo_pkt_arb
// Self-checking bench for hssi_fifo_pkt_arb (NUM_REQ=2, DATA_W=64, SRC_W=3).
// Each requester draws beats from its own packet queue. A transaction-level
// reference (owner / last owner as integers, queues of beats) predicts ready,
// grant, the written word stream, pkt_cnt and proto_err every cycle.
// -----------------------------------------------------------------------------
module tb_hssi_fifo_pkt_arb;
  import hssi_fifo_arb_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int DATA_W  = 64;
  localparam int SRC_W   = 3;
  localparam int WORD_W  = DATA_W + SRC_W + 2;
  localparam int SRC_LSB = DATA_W + 2;
  localparam int SOP_BIT = DATA_W + 1;

  typedef struct {
    logic [DATA_W-1:0] data;
    bit                sop;
    bit                eop;
  } beat_t;

  logic                      clock;
  logic                      sclr;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_sop;
  logic [NUM_REQ-1:0]        req_eop;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      fifo_wrreq;
  logic [WORD_W-1:0]         fifo_data;
  logic                      fifo_almost_full;
  logic [NUM_REQ-1:0]        grant;
  logic                      proto_err;
  logic [15:0]               pkt_cnt;

  hssi_fifo_pkt_arb #(
    .NUM_REQ (NUM_REQ),
    .DATA_W  (DATA_W),
    .SRC_W   (SRC_W)
  ) dut (
    .clock            (clock),
    .sclr             (sclr),
    .req_valid        (req_valid),
    .req_data         (req_data),
    .req_sop          (req_sop),
    .req_eop          (req_eop),
    .req_ready        (req_ready),
    .fifo_wrreq       (fifo_wrreq),
    .fifo_data        (fifo_data),
    .fifo_almost_full (fifo_almost_full),
    .grant            (grant),
    .proto_err        (proto_err),
    .pkt_cnt          (pkt_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Stimulus sources and knobs
  beat_t             src_q [NUM_REQ][$];
  logic [WORD_W-1:0] exp_words[$];
  int                valid_pct [NUM_REQ];
  int                af_pct;
  int                af_burst;
  bit                arm_af;
  bit                sclr_req;

  // Reference state: what the registered outputs should show after the edge
  bit                m_busy;
  int                m_owner;
  int                m_last;
  bit                m_first;
  bit                m_err;
  logic [15:0]       m_cnt;
  bit                m_wr;
  logic [WORD_W-1:0] m_data;

  // Observation logs
  logic [WORD_W-1:0] wr_log[$];
  int                wr_cyc[$];
  int                cyc;
  bit                count_stall;
  int                stall_cnt;

  function automatic logic [NUM_REQ-1:0] exp_grant();
    logic [NUM_REQ-1:0] g;
    g = '0;
    if (m_busy) g[m_owner] = 1'b1;
    return g;
  endfunction

  task automatic add_pkt(input int r, input int len, input bit bad_first);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data = {$urandom, $urandom};
      b.sop  = (k == 0) ? !bad_first : 1'b0;
      b.eop  = (k == len - 1);
      src_q[r].push_back(b);
      exp_words.push_back({SRC_W'(r), b.sop, b.eop, b.data});
    end
  endtask

  task automatic model_reset();
    m_busy  = 0;
    m_owner = 0;
    m_last  = NUM_REQ - 1;
    m_first = 0;
    m_err   = 0;
    m_cnt   = '0;
    m_wr    = 0;
    m_data  = '0;
  endtask

  // One clock cycle: check registered outputs, drive inputs, check ready,
  // then advance the reference across the coming rising edge.
  task automatic step();
    logic [NUM_REQ-1:0] v;
    logic [NUM_REQ-1:0] rdy;
    bit                 af;
    beat_t              b;
    @(negedge clock);
    cyc++;
    check("grant", grant, exp_grant());
    check("fifo_wrreq", fifo_wrreq, m_wr);
    check("fifo_data", fifo_data, m_data);
    check("pkt_cnt", pkt_cnt, m_cnt);
    check("proto_err", proto_err, m_err);
    if (fifo_wrreq === 1'b1) begin
      wr_log.push_back(fifo_data);
      wr_cyc.push_back(cyc);
    end

    if (arm_af && m_busy && m_owner == 0 && src_q[0].size() == 3) begin
      af_burst = 5;
      arm_af   = 0;
    end
    if (af_burst > 0) begin
      af = 1;
      af_burst--;
    end else begin
      af = ($urandom_range(99) < af_pct);
    end
    fifo_almost_full = af;
    v = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_data[i*DATA_W +: DATA_W] = '0;
      req_sop[i] = 1'b0;
      req_eop[i] = 1'b0;
      if (src_q[i].size() > 0) begin
        v[i] = ($urandom_range(99) < valid_pct[i]);
        req_data[i*DATA_W +: DATA_W] = src_q[i][0].data;
        req_sop[i] = src_q[i][0].sop;
        req_eop[i] = src_q[i][0].eop;
      end
    end
    req_valid = v;
    sclr      = sclr_req;
    sclr_req  = 0;
    #1;
    rdy = '0;
    if (m_busy && !af) rdy[m_owner] = 1'b1;
    check("req_ready", req_ready, rdy);
    if (count_stall && m_busy && v[m_owner] && req_ready[m_owner] !== 1'b1) stall_cnt++;

    if (sclr) begin
      model_reset();
      for (int i = 0; i < NUM_REQ; i++) src_q[i].delete();
    end else if (!m_busy) begin
      m_wr = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
        int c;
        c = (m_last + k) % NUM_REQ;
        if (!m_busy && v[c]) begin
          m_busy  = 1;
          m_owner = c;
          m_first = 1;
        end
      end
    end else begin
      m_wr = 0;
      if (v[m_owner] && !af) begin
        b      = src_q[m_owner].pop_front();
        m_wr   = 1;
        m_data = {SRC_W'(m_owner), b.sop, b.eop, b.data};
        if (b.sop != m_first) m_err = 1;
        m_first = 0;
        if (b.eop) begin
          m_busy = 0;
          m_last = m_owner;
          m_cnt  = m_cnt + 16'd1;
        end
      end
    end
  endtask

  task automatic run_until_idle(input int max_cyc);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while ((src_q[0].size() > 0 || src_q[1].size() > 0 || m_busy) && n < max_cyc);
    check("drain_within_budget", 128'(n < max_cyc), 128'(1));
    step();  // let the final write become visible and get logged
    step();
  endtask

  task automatic new_scenario();
    wr_log.delete();
    wr_cyc.delete();
    exp_words.delete();
    for (int i = 0; i < NUM_REQ; i++) valid_pct[i] = 100;
    af_pct      = 0;
    af_burst    = 0;
    arm_af      = 0;
    count_stall = 0;
    stall_cnt   = 0;
  endtask

  initial begin
    logic [15:0] cnt0;
    int          nw;
    sclr             = 1'b1;
    req_valid        = '0;
    req_data         = '0;
    req_sop          = '0;
    req_eop          = '0;
    fifo_almost_full = 1'b0;
    sclr_req         = 0;
    cyc              = 0;
    new_scenario();
    model_reset();
    repeat (3) @(posedge clock);
    @(negedge clock);
    sclr = 1'b0;
    check("rst_grant", grant, '0);
    check("rst_ready", req_ready, '0);
    check("rst_wrreq", fifo_wrreq, 1'b0);
    check("rst_data", fifo_data, '0);
    check("rst_err", proto_err, 1'b0);
    check("rst_cnt", pkt_cnt, '0);

    // Both requesters send one 3-beat packet from reset: 0 goes first.
    new_scenario();
    add_pkt(0, 3, 0);
    add_pkt(1, 3, 0);
    run_until_idle(100);
    check("s1_nwrites", wr_log.size(), 6);
    for (int i = 0; i < 6 && i < wr_log.size(); i++)
      check("s1_src", wr_log[i][SRC_LSB +: SRC_W], (i < 3) ? 0 : 1);
    check("s1_pkt_cnt", pkt_cnt, 2);

    // Requester 1 always has packets ready; grants must alternate.
    new_scenario();
    for (int p = 0; p < 4; p++) begin
      add_pkt(0, 2, 0);
      add_pkt(1, 2, 0);
    end
    run_until_idle(200);
    nw = 0;
    foreach (wr_log[i]) begin
      if (wr_log[i][DATA_W] == 1'b1) begin
        check("s2_alt_owner", wr_log[i][SRC_LSB +: SRC_W], nw % 2);
        nw++;
      end
    end
    check("s2_npkts", nw, 8);

    // almost_full held 5 cycles while beat 2 of 4 is pending.
    new_scenario();
    add_pkt(0, 4, 0);
    arm_af      = 1;
    count_stall = 1;
    run_until_idle(100);
    check("s3_stall_cycles", stall_cnt, 5);
    check("s3_nwrites", wr_log.size(), 4);
    for (int i = 0; i < 4 && i < wr_log.size(); i++)
      check("s3_beat", wr_log[i], exp_words[i]);

    // Back-to-back single-beat packets: one write every 2 cycles.
    new_scenario();
    cnt0 = pkt_cnt;
    for (int p = 0; p < 5; p++) add_pkt(0, 1, 0);
    run_until_idle(100);
    check("s4_nwrites", wr_log.size(), 5);
    for (int i = 1; i < wr_cyc.size(); i++)
      check("s4_gap", wr_cyc[i] - wr_cyc[i-1], 2);
    check("s4_pkt_cnt", pkt_cnt, cnt0 + 16'd5);

    // First beat without sop: error sets, is sticky, data still forwarded.
    new_scenario();
    add_pkt(0, 2, 1);
    run_until_idle(100);
    check("s5_nwrites", wr_log.size(), 2);
    if (wr_log.size() > 0) check("s5_fwd", wr_log[0], exp_words[0]);
    repeat (4) step();
    check("s5_err_sticky", proto_err, 1'b1);

    // sclr mid-packet of requester 1 (last owner 0): afterwards 0 wins.
    new_scenario();
    add_pkt(1, 4, 0);
    nw = 0;
    while (wr_log.size() < 2 && nw < 50) begin
      step();
      nw++;
    end
    check("s6_reach_mid", 128'(nw < 50), 128'(1));
    sclr_req = 1;
    step();
    @(posedge clock);
    #1;
    check("s6_grant", grant, '0);
    check("s6_cnt", pkt_cnt, '0);
    check("s6_err", proto_err, 1'b0);
    check("s6_ready", req_ready, '0);
    wr_log.delete();
    add_pkt(0, 2, 0);
    add_pkt(1, 2, 0);
    run_until_idle(100);
    check("s6_nwrites", wr_log.size(), 4);
    if (wr_log.size() > 0) check("s6_first_src", wr_log[0][SRC_LSB +: SRC_W], 0);

    // Randomized traffic with random back-pressure and valid gaps.
    new_scenario();
    valid_pct[0] = 70;
    valid_pct[1] = 70;
    af_pct       = 20;
    for (int c = 0; c < 600; c++) begin
      for (int r = 0; r < NUM_REQ; r++)
        if (src_q[r].size() < 2)
          add_pkt(r, $urandom_range(1, 4), ($urandom_range(19) == 0));
      step();
    end
    af_pct = 0;
    run_until_idle(400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
